test_wavegen: RTL and testbench
===============================

Name: test_wavegen

Overview:
Multi-waveform digital signal generator clocked at 50 MHz, driven by a 32-bit phase accumulator. It produces square, sawtooth, triangle, sine and synthetic ECG waveforms as signed 16-bit samples, plus a 1-bit square "level" output. Frequency, square duty cycle and sweep direction are selectable from board-level switches. It feeds the downstream DAC/DSP path.

Parameters:
CLK_HZ, 50000000, system clock frequency; the tuning words are derived from it.
PHASE_W, 32, phase accumulator width.
LUT_AW, 8, sine/ECG LUT address width (256 entries).

Ports:
clk  in  1  system clock, 50 MHz, rising edge.
rst  in  1  asynchronous active-low reset.
dc  in  2  square duty select.
dc_in  in  1  sweep direction; 1 = phase increments, 0 = phase decrements.
sel  in  2  output frequency select.
level  out  1  digital square wave; 1 during the duty-high portion.
square_out  out  16 signed  square sample.
saw_out  out  16 signed  sawtooth sample.
trig_out  out  16 signed  triangle sample.
sin_out  out  16 signed  sine sample.
ecg_out  out  16 signed  synthetic ECG sample.

Behaviour:
- Reset (rst=0, asynchronous): phase=0; all 16-bit outputs=0; level=0. On release, the accumulator advances on the first clk edge.
- Tuning word FTW by sel:
  - 00 -> 85899 (1 kHz, period 50000 cycles).
  - 01 -> 858993 (10 kHz).
  - 10 -> 4294967 (50 kHz, period 1000 cycles).
  - 11 -> 8589935 (100 kHz).
- Each clk edge: phase <= phase + FTW if dc_in=1, otherwise phase - FTW. Arithmetic is modulo 2^32, so wrap-around is natural.
- A change of sel or dc_in takes effect on the next edge. Phase is continuous and is never reset by these changes.
- All outputs are registered from the current phase, so outputs lag the phase register by 1 cycle.
- p = phase[31:24] (LUT index); h = phase[31:16].
- Duty threshold D from dc:
  - 00 -> 0x20 (12.5%).
  - 01 -> 0x40 (25%).
  - 10 -> 0x80 (50%).
  - 11 -> 0xC0 (75%).
- level = (p < D).
- square_out = +32767 when level, else -32767.
- saw_out = h XOR 0x8000. This rises from -32768 to +32767 over one period when dc_in=1 and falls when dc_in=0.
- trig_out: t = phase[31] ? ~phase[30:15] : phase[30:15], then out = t XOR 0x8000. Peak +32767 at phase 0x80000000; minimum -32768 at phase 0.
- sin_out = SINLUT[p], where SINLUT[k] = round(32767*sin(2πk/256)).
  - Key values: SINLUT[0]=0, SINLUT[64]=32767, SINLUT[192]=-32767.
- ecg_out = ECGLUT[p], one beat per period; baseline 0 elsewhere.
  - P wave: half-sine over indices 20..40, peak +4000 at 30.
  - Q: linear 0 -> -3000 over 56..60.
  - R: linear -3000 -> +30000 over 60..66; peak ECGLUT[66]=30000.
  - S: linear 30000 -> -8000 over 66..72.
  - Return: linear -8000 -> 0 over 72..76.
  - T wave: half-sine over 110..150, peak +8000 at 130.
- A dc change alters level/square on the next output update only. No glitch beyond one sample is permitted.
- Reset asserted mid-operation: all state clears immediately, regardless of clk.

Decomposition:
- Package test_wavegen_pkg: FTW constants per sel, duty thresholds per dc, amplitude constants (32767, -32767), ECG key-point constants.
- One sub-module: test_wave_rom. It is a combinational or registered 256x16 sine plus 256x16 ECG ROM indexed by p.
- If the ROM is registered, the top module compensates so the total latency stays at 1 cycle from phase.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, level 0. After release, saw_out increases monotonically with dc_in=1.
- sel=00, dc=10, dc_in=1, run 200000 cycles:
  - saw_out wraps every 50000±1 cycles.
  - level high 25000±1 cycles per period.
  - sin_out reaches 32767 at phase quarter.
- Duty sweep at sel=10: dc=00/01/11 -> level high 125/250/750 ±1 cycles of each 1000-cycle period.
- Direction: dc_in switched to 0 -> saw_out strictly decreasing (except at wrap). Triangle and sine retrace; phase is continuous at the switch instant.
- sel=10 -> sin_out period 1000±1 cycles. Switching sel mid-period -> no phase jump; only the rate changes.
- ECG: force phase index 66 -> ecg_out=30000 one cycle later. Index 0 -> 0. Index 72 -> -8000.

Source files
------------

// File: rtl/test_wavegen_pkg.sv
// Shared types, tuning words, duty thresholds and LUT generators for the
// phase-accumulator waveform generator.
package test_wavegen_pkg;

  localparam int CLK_HZ  = 32'sd50000000;
  localparam int PHASE_W = 32'sd32;
  localparam int LUT_AW  = 32'sd8;
  localparam int LUT_N   = 32'sd256;

  typedef logic signed [15:0] sample_t;
  typedef enum logic [1:0] {SEL_1K = 2'b00, SEL_10K = 2'b01, SEL_50K = 2'b10, SEL_100K = 2'b11} sel_e;
  typedef enum logic [1:0] {DUTY_12 = 2'b00, DUTY_25 = 2'b01, DUTY_50 = 2'b10, DUTY_75 = 2'b11} duty_e;

  // Rounded 2^PHASE_W * hz / CLK_HZ
  function automatic logic [PHASE_W-1:0] calc_ftw(input logic [63:0] hz);
    logic [63:0] num;
    num = (64'd1 << PHASE_W) * hz + 64'(CLK_HZ / 32'sd2);
    return PHASE_W'(num / 64'(CLK_HZ));
  endfunction

  localparam logic [PHASE_W-1:0] FTW_1K   = calc_ftw(64'd1000);
  localparam logic [PHASE_W-1:0] FTW_10K  = calc_ftw(64'd10000);
  localparam logic [PHASE_W-1:0] FTW_50K  = calc_ftw(64'd50000);
  localparam logic [PHASE_W-1:0] FTW_100K = calc_ftw(64'd100000);

  localparam logic [7:0] DUTY_TH_12 = 8'h20;
  localparam logic [7:0] DUTY_TH_25 = 8'h40;
  localparam logic [7:0] DUTY_TH_50 = 8'h80;
  localparam logic [7:0] DUTY_TH_75 = 8'hC0;

  localparam sample_t    AMP_POS   = 16'sd32767;
  localparam sample_t    AMP_NEG   = -16'sd32767;
  localparam logic [15:0] SIGN_FLIP = 16'h8000;

  localparam int ECG_P_PEAK = 32'sd4000;
  localparam int ECG_Q_MIN  = -32'sd3000;
  localparam int ECG_R_PEAK = 32'sd30000;
  localparam int ECG_S_MIN  = -32'sd8000;
  localparam int ECG_T_PEAK = 32'sd8000;

  localparam real PI = 3.14159265358979323846;

  function automatic logic [PHASE_W-1:0] ftw_of(input logic [1:0] sel);
    case (sel_e'(sel))
      SEL_1K:   return FTW_1K;
      SEL_10K:  return FTW_10K;
      SEL_50K:  return FTW_50K;
      SEL_100K: return FTW_100K;
      default:  return FTW_1K;
    endcase
  endfunction

  function automatic logic [7:0] duty_of(input logic [1:0] dc);
    case (duty_e'(dc))
      DUTY_12: return DUTY_TH_12;
      DUTY_25: return DUTY_TH_25;
      DUTY_50: return DUTY_TH_50;
      DUTY_75: return DUTY_TH_75;
      default: return DUTY_TH_50;
    endcase
  endfunction

  function automatic sample_t sin_val(input int k);
    real x;
    int  r;
    x = 32767.0 * $sin(2.0 * PI * real'(k) / 256.0);
    r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return sample_t'(r);
  endfunction

  // Half-sine lobe: idx 0..128 spans one half period of the sine table
  function automatic int half_sine(input int amp, input int idx);
    return (amp * int'(sin_val(idx)) + 32'sd16383) / 32'sd32767;
  endfunction

  function automatic sample_t ecg_val(input int k);
    int v;
    if (k >= 32'sd20 && k <= 32'sd40)
      v = half_sine(ECG_P_PEAK, ((k - 32'sd20) * 32'sd32) / 32'sd5);
    else if (k >= 32'sd57 && k <= 32'sd60)
      v = (ECG_Q_MIN * (k - 32'sd56)) / 32'sd4;
    else if (k >= 32'sd61 && k <= 32'sd66)
      v = ECG_Q_MIN + ((ECG_R_PEAK - ECG_Q_MIN) * (k - 32'sd60)) / 32'sd6;
    else if (k >= 32'sd67 && k <= 32'sd72)
      v = ECG_R_PEAK + ((ECG_S_MIN - ECG_R_PEAK) * (k - 32'sd66)) / 32'sd6;
    else if (k >= 32'sd73 && k <= 32'sd75)
      v = ECG_S_MIN + ((32'sd0 - ECG_S_MIN) * (k - 32'sd72)) / 32'sd4;
    else if (k >= 32'sd110 && k <= 32'sd150)
      v = half_sine(ECG_T_PEAK, ((k - 32'sd110) * 32'sd16) / 32'sd5);
    else
      v = 32'sd0;
    return sample_t'(v);
  endfunction

endpackage

// File: rtl/test_wavegen_if.sv
// Control inputs and sample outputs of the waveform generator.
interface test_wavegen_if;
  import test_wavegen_pkg::*;

  logic [1:0] dc;
  logic       dc_in;
  logic [1:0] sel;
  logic       level;
  sample_t    square_out;
  sample_t    saw_out;
  sample_t    trig_out;
  sample_t    sin_out;
  sample_t    ecg_out;

  modport master (
    output dc, dc_in, sel,
    input  level, square_out, saw_out, trig_out, sin_out, ecg_out
  );

  modport slave (
    input  dc, dc_in, sel,
    output level, square_out, saw_out, trig_out, sin_out, ecg_out
  );

endinterface

// File: rtl/test_wavegen_rom.sv
// Combinational 256-entry sine and ECG tables; the top registers the reads
// so the sample still lags the phase by a single cycle.
module test_wave_rom
  import test_wavegen_pkg::*;
(
  input  logic [LUT_AW-1:0] addr,
  output sample_t           sin_data,
  output sample_t           ecg_data
);

  sample_t sin_tab_s [LUT_N];
  sample_t ecg_tab_s [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_tab
    assign sin_tab_s[k] = sin_val(k);
    assign ecg_tab_s[k] = ecg_val(k);
  end

  assign sin_data = sin_tab_s[addr];
  assign ecg_data = ecg_tab_s[addr];

endmodule

// File: rtl/test_wavegen.sv
// Phase-accumulator generator: square/level, saw, triangle, sine and ECG
// samples, all registered from the current phase.
module test_wavegen
  import test_wavegen_pkg::*;
(
  input logic           clk,
  input logic           rst,
  test_wavegen_if.slave bus
);

  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] ftw_s;
  logic [LUT_AW-1:0]  p_s;
  logic [15:0]        h_s;
  logic [15:0]        trig_s;
  logic [7:0]         duty_s;
  logic               level_s;
  sample_t            sin_s;
  sample_t            ecg_s;

  logic    level_r;
  sample_t square_r;
  sample_t saw_r;
  sample_t trig_r;
  sample_t sin_r;
  sample_t ecg_r;

  // Phase taps, duty compare and triangle fold
  always_comb begin
    ftw_s   = ftw_of(bus.sel);
    duty_s  = duty_of(bus.dc);
    p_s     = phase_r[PHASE_W-1 -: LUT_AW];
    h_s     = phase_r[PHASE_W-1 -: 16];
    level_s = (p_s < duty_s);
    if (phase_r[PHASE_W-1])
      trig_s = ~phase_r[PHASE_W-2 -: 16];
    else
      trig_s = phase_r[PHASE_W-2 -: 16];
  end

  test_wave_rom u_rom (
    .addr     (p_s),
    .sin_data (sin_s),
    .ecg_data (ecg_s)
  );

  // Accumulator and output sample registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r  <= '0;
      level_r  <= 1'b0;
      square_r <= '0;
      saw_r    <= '0;
      trig_r   <= '0;
      sin_r    <= '0;
      ecg_r    <= '0;
    end else begin
      if (bus.dc_in)
        phase_r <= phase_r + ftw_s;
      else
        phase_r <= phase_r - ftw_s;
      level_r  <= level_s;
      square_r <= level_s ? AMP_POS : AMP_NEG;
      saw_r    <= sample_t'(h_s ^ SIGN_FLIP);
      trig_r   <= sample_t'(trig_s ^ SIGN_FLIP);
      sin_r    <= sin_s;
      ecg_r    <= ecg_s;
    end
  end

  assign bus.level      = level_r;
  assign bus.square_out = square_r;
  assign bus.saw_out    = saw_r;
  assign bus.trig_out   = trig_r;
  assign bus.sin_out    = sin_r;
  assign bus.ecg_out    = ecg_r;

endmodule

// File: tb/tb_test_wavegen.sv
// Directed bench for test_wavegen: reset, period/duty timing, direction,
// frequency switching and LUT key points against a small phase model.
module tb_test_wavegen;

  logic clk = 1'b0;
  logic rst = 1'b0;

  test_wavegen_if bus ();

  test_wavegen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int n_total   = 32'sd0;
  int n_pass    = 32'sd0;
  int model_err = 32'sd0;

  logic [31:0] ph_m    = 32'd0;
  logic [31:0] prev_m  = 32'd0;
  logic [1:0]  dc_edge = 2'b00;

  logic [1:0] dcs  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         hexp [4] = '{32'sd125, 32'sd250, 32'sd750, 32'sd500};

  function automatic logic [31:0] ftw_m(input logic [1:0] s);
    case (s)
      2'b00:   return 32'd85899;
      2'b01:   return 32'd858993;
      2'b10:   return 32'd4294967;
      default: return 32'd8589935;
    endcase
  endfunction

  function automatic logic [7:0] duty_m(input logic [1:0] d);
    case (d)
      2'b00:   return 8'h20;
      2'b01:   return 8'h40;
      2'b10:   return 8'h80;
      default: return 8'hC0;
    endcase
  endfunction

  function automatic logic signed [15:0] saw_m(input logic [31:0] ph);
    return ph[31:16] ^ 16'h8000;
  endfunction

  function automatic logic signed [15:0] trig_m(input logic [31:0] ph);
    logic [15:0] t;
    t = ph[31] ? ~ph[30:15] : ph[30:15];
    return t ^ 16'h8000;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    n_total++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  // One clock: advance the model in step with the DUT, sample at negedge
  task automatic step();
    @(posedge clk);
    prev_m  = ph_m;
    dc_edge = bus.dc;
    if (!rst)           ph_m = 32'd0;
    else if (bus.dc_in) ph_m = ph_m + ftw_m(bus.sel);
    else                ph_m = ph_m - ftw_m(bus.sel);
    @(negedge clk);
  endtask

  task automatic model_cmp();
    logic lvl;
    lvl = (prev_m[31:24] < duty_m(dc_edge));
    if (bus.saw_out !== saw_m(prev_m) || bus.trig_out !== trig_m(prev_m) ||
        bus.level !== lvl || bus.square_out !== (lvl ? 16'sd32767 : -16'sd32767))
      model_err++;
  endtask

  initial begin
    int c, high, wrap_at, bad, ev0, ev1, hits;
    logic signed [15:0] last;
    logic seen_peak;
    logic [6:0] done;

    bus.sel   = 2'($urandom);
    bus.dc    = 2'($urandom);
    bus.dc_in = 1'($urandom);
    repeat (3) step();
    chk("rst_level",  bus.level,      32'sd0);
    chk("rst_square", bus.square_out, 32'sd0);
    chk("rst_saw",    bus.saw_out,    32'sd0);
    chk("rst_trig",   bus.trig_out,   32'sd0);
    chk("rst_sin",    bus.sin_out,    32'sd0);
    chk("rst_ecg",    bus.ecg_out,    32'sd0);

    // Release at 1 kHz, 50 % duty, counting up; first sample reflects phase 0
    bus.sel = 2'b00; bus.dc = 2'b10; bus.dc_in = 1'b1;
    rst = 1'b1;
    step();
    chk("p0_saw",    bus.saw_out,    -32'sd32768);
    chk("p0_trig",   bus.trig_out,   -32'sd32768);
    chk("p0_sin",    bus.sin_out,    32'sd0);
    chk("p0_ecg",    bus.ecg_out,    32'sd0);
    chk("p0_level",  bus.level,      32'sd1);
    chk("p0_square", bus.square_out, 32'sd32767);

    c = 0; high = int'(bus.level); wrap_at = -1; seen_peak = 1'b0; last = bus.saw_out;
    while (wrap_at < 0 && c < 52000) begin
      step(); c++;
      model_cmp();
      if (bus.saw_out < last) wrap_at = c;
      else if (bus.level) high++;
      if (bus.sin_out == 16'sd32767) seen_peak = 1'b1;
      last = bus.saw_out;
    end
    chk_rng("saw_wrap_1k", wrap_at, 32'sd49999, 32'sd50001);
    chk_rng("level_high_1k", high, 32'sd24999, 32'sd25001);
    chk("sin_peak_1k", seen_peak, 32'sd1);

    // Duty sweep at 50 kHz
    bus.sel = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus.dc = dcs[i];
      step(); model_cmp();
      step(); model_cmp();
      high = 0;
      repeat (1000) begin
        step(); model_cmp();
        if (bus.level) high++;
      end
      chk_rng($sformatf("level_high_dc%0d", dcs[i]), high, hexp[i] - 1, hexp[i] + 1);
    end

    // Reverse direction: saw must fall every cycle except at the wrap
    bus.dc_in = 1'b0;
    step(); model_cmp();
    last = bus.saw_out; bad = 0;
    repeat (1000) begin
      step(); model_cmp();
      if (bus.saw_out >= last && (int'(bus.saw_out) - int'(last)) < 32'sd16384) bad++;
      last = bus.saw_out;
    end
    chk("saw_down_bad", bad, 32'sd0);

    // Sine period at 50 kHz
    bus.dc_in = 1'b1;
    ev0 = -1; ev1 = -1; c = 0; last = bus.sin_out;
    while (ev1 < 0 && c < 2200) begin
      step(); c++; model_cmp();
      if (bus.sin_out == 16'sd32767 && last != 16'sd32767) begin
        if (ev0 < 0) ev0 = c;
        else ev1 = c;
      end
      last = bus.sin_out;
    end
    chk_rng("sin_period_50k", ev1 - ev0, 32'sd999, 32'sd1001);

    // Frequency switch mid-period: phase continuity is covered by the model
    repeat (300) begin step(); model_cmp(); end
    bus.sel = 2'b11;
    repeat (300) begin step(); model_cmp(); end

    // LUT key points at 100 kHz
    done = 7'd0; hits = 0; c = 0;
    while (hits < 7 && c < 700) begin
      step(); c++; model_cmp();
      case (prev_m[31:24])
        8'd66:   if (!done[0]) begin done[0] = 1'b1; hits++; chk("ecg_r_66",  bus.ecg_out, 32'sd30000); end
        8'd72:   if (!done[1]) begin done[1] = 1'b1; hits++; chk("ecg_s_72",  bus.ecg_out, -32'sd8000); end
        8'd0:    if (!done[2]) begin done[2] = 1'b1; hits++; chk("ecg_0",     bus.ecg_out, 32'sd0);     end
        8'd30:   if (!done[3]) begin done[3] = 1'b1; hits++; chk("ecg_p_30",  bus.ecg_out, 32'sd4000);  end
        8'd130:  if (!done[4]) begin done[4] = 1'b1; hits++; chk("ecg_t_130", bus.ecg_out, 32'sd8000);  end
        8'd64:   if (!done[5]) begin done[5] = 1'b1; hits++; chk("sin_64",    bus.sin_out, 32'sd32767); end
        8'd192:  if (!done[6]) begin done[6] = 1'b1; hits++; chk("sin_192",   bus.sin_out, -32'sd32767); end
        default: ;
      endcase
    end
    chk("lut_points_hit", hits, 32'sd7);
    chk("model_mismatches", model_err, 32'sd0);

    // Asynchronous reset between clock edges
    #3;
    rst = 1'b0;
    #1;
    chk("arst_level",  bus.level,      32'sd0);
    chk("arst_square", bus.square_out, 32'sd0);
    chk("arst_saw",    bus.saw_out,    32'sd0);
    chk("arst_trig",   bus.trig_out,   32'sd0);
    chk("arst_sin",    bus.sin_out,    32'sd0);
    chk("arst_ecg",    bus.ecg_out,    32'sd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
